// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes and width defaults.
package alu_share_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int OP_WIDTH_DEF    = 4;
    localparam int SHAMT_WIDTH_DEF = 5;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_JR  = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_LW  = 4'b1011;
    localparam logic [3:0] OP_SW  = 4'b1100;
    localparam logic [3:0] OP_JAL = 4'b1111;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way arbiter; remembers the last winner so a contested grant can alternate.
module rr_arbiter_2 #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (FAIR != 0 && !last_grant) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Reset value of 1 lets requester 0 win the first contest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: arbitrate, register issue, buffer results.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int OP_WIDTH    = OP_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF,
    parameter int FAIR        = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [OP_WIDTH-1:0]    req0_op,
    input  logic [OP_WIDTH-1:0]    req1_op,
    input  logic [DATA_WIDTH-1:0]  req0_a,
    input  logic [DATA_WIDTH-1:0]  req1_a,
    input  logic [DATA_WIDTH-1:0]  req0_b,
    input  logic [DATA_WIDTH-1:0]  req1_b,
    input  logic [DATA_WIDTH-1:0]  req0_c,
    input  logic [DATA_WIDTH-1:0]  req1_c,
    input  logic [SHAMT_WIDTH-1:0] req0_shamt,
    input  logic [SHAMT_WIDTH-1:0] req1_shamt,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp0_result,
    output logic [DATA_WIDTH-1:0]  rsp1_result,
    output logic                   rsp0_zero,
    output logic                   rsp1_zero,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    output logic [DATA_WIDTH-1:0]  alu_c,
    output logic [SHAMT_WIDTH-1:0] alu_shamt,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_zero,
    output logic                   busy
);

    logic                  issue_valid;
    logic                  issue_owner;
    logic [1:0]            capture;
    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic [1:0]            rsp_full;
    logic [DATA_WIDTH-1:0] rsp_result [2];
    logic [1:0]            rsp_zero;

    // One outstanding op per requester: in the issue stage or in its buffer.
    assign capture  = issue_valid ? (issue_owner ? 2'b10 : 2'b01) : 2'b00;
    assign eligible = req_valid & ~rsp_full & ~capture;

    rr_arbiter_2 #(
        .FAIR(FAIR)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req_ready = grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid <= 1'b0;
            issue_owner <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_c       <= '0;
            alu_shamt   <= '0;
        end else begin
            issue_valid <= |grant;
            if (grant[0]) begin
                issue_owner <= 1'b0;
                alu_op      <= req0_op;
                alu_a       <= req0_a;
                alu_b       <= req0_b;
                alu_c       <= req0_c;
                alu_shamt   <= req0_shamt;
            end else if (grant[1]) begin
                issue_owner <= 1'b1;
                alu_op      <= req1_op;
                alu_a       <= req1_a;
                alu_b       <= req1_b;
                alu_c       <= req1_c;
                alu_shamt   <= req1_shamt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_full      <= 2'b00;
            rsp_zero      <= 2'b00;
            rsp_result[0] <= '0;
            rsp_result[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    rsp_full[i]   <= 1'b1;
                    rsp_result[i] <= alu_result;
                    rsp_zero[i]   <= alu_zero;
                end else if (rsp_ready[i]) begin
                    rsp_full[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid   = rsp_full;
    assign rsp0_result = rsp_result[0];
    assign rsp1_result = rsp_result[1];
    assign rsp0_zero   = rsp_zero[0];
    assign rsp1_zero   = rsp_zero[1];
    assign busy        = issue_valid | (|rsp_full);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share one stimulus.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic [1:0]  rrdy = 2'b00;
    logic [3:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, c0 = '0;
    logic [31:0] a1 = '0, b1 = '0, c1 = '0;
    logic [4:0]  sh0 = '0, sh1 = '0;

    logic [1:0]  f_ready, f_rv, p_ready, p_rv;
    logic [31:0] f_r0, f_r1, p_r0, p_r1;
    logic        f_z0, f_z1, p_z0, p_z1;
    logic [3:0]  f_op, p_op;
    logic [31:0] f_a, f_b, f_c, p_a, p_b, p_c;
    logic [4:0]  f_sh, p_sh;
    logic [31:0] f_res, p_res;
    logic        f_busy, p_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural model of the external ALU.
    function automatic logic [31:0] alu(input logic [3:0] op,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] c, input logic [4:0] sh);
        case (op)
            4'b0001: return a & b;
            4'b0011: return ~(a | b);
            4'b0100: return a | b;
            4'b0101: return b << sh;
            4'b0110: return b >> sh;
            4'b0111: return a - b;
            4'b1111: return c + 32'd4;
            default: return a + b;
        endcase
    endfunction

    assign f_res = alu(f_op, f_a, f_b, f_c, f_sh);
    assign p_res = alu(p_op, p_a, p_b, p_c, p_sh);

    alu_share_arbiter #(.FAIR(1)) dut_f (
        .clk(clk), .reset(reset),
        .req_valid(valid), .req_ready(f_ready),
        .req0_op(op0), .req1_op(op1),
        .req0_a(a0), .req1_a(a1), .req0_b(b0), .req1_b(b1),
        .req0_c(c0), .req1_c(c1),
        .req0_shamt(sh0), .req1_shamt(sh1),
        .rsp_valid(f_rv), .rsp_ready(rrdy),
        .rsp0_result(f_r0), .rsp1_result(f_r1),
        .rsp0_zero(f_z0), .rsp1_zero(f_z1),
        .alu_op(f_op), .alu_a(f_a), .alu_b(f_b), .alu_c(f_c),
        .alu_shamt(f_sh),
        .alu_result(f_res), .alu_zero(f_res == 32'd0),
        .busy(f_busy)
    );

    alu_share_arbiter #(.FAIR(0)) dut_p (
        .clk(clk), .reset(reset),
        .req_valid(valid), .req_ready(p_ready),
        .req0_op(op0), .req1_op(op1),
        .req0_a(a0), .req1_a(a1), .req0_b(b0), .req1_b(b1),
        .req0_c(c0), .req1_c(c1),
        .req0_shamt(sh0), .req1_shamt(sh1),
        .rsp_valid(p_rv), .rsp_ready(rrdy),
        .rsp0_result(p_r0), .rsp1_result(p_r1),
        .rsp0_zero(p_z0), .rsp1_zero(p_z1),
        .alu_op(p_op), .alu_a(p_a), .alu_b(p_b), .alu_c(p_c),
        .alu_shamt(p_sh),
        .alu_result(p_res), .alu_zero(p_res == 32'd0),
        .busy(p_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid = 2'b00;
        rrdy  = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [1:0] fg  [9] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01,
                            2'b00, 2'b10, 2'b01, 2'b00};
    logic [1:0] frv [9] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00,
                            2'b10, 2'b01, 2'b00, 2'b10};
    logic [1:0] pg  [9] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10,
                            2'b00, 2'b01, 2'b10, 2'b00};
    logic [1:0] prv [9] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00,
                            2'b01, 2'b10, 2'b00, 2'b01};

    initial begin
        // Reset state
        tick();
        chk("rst_f_ready", {30'd0, f_ready}, 32'd0);
        chk("rst_f_rv", {30'd0, f_rv}, 32'd0);
        chk("rst_f_busy", {31'd0, f_busy}, 32'd0);
        chk("rst_f_alu_a", f_a, 32'd0);
        chk("rst_f_r0", f_r0, 32'd0);
        chk("rst_p_rv", {30'd0, p_rv}, 32'd0);
        reset = 1'b1;
        tick();

        // 1: single ADD on requester 0
        valid = 2'b01; op0 = 4'b0000; a0 = 32'd5; b0 = 32'd7;
        #1;
        chk("t1_f_ready", {30'd0, f_ready}, 32'd1);
        chk("t1_p_ready", {30'd0, p_ready}, 32'd1);
        tick();
        valid = 2'b00;
        chk("t1_alu_op", {28'd0, f_op}, 32'd0);
        chk("t1_alu_a", f_a, 32'd5);
        chk("t1_alu_b", f_b, 32'd7);
        chk("t1_busy", {31'd0, f_busy}, 32'd1);
        chk("t1_rv_n1", {30'd0, f_rv}, 32'd0);
        tick();
        chk("t1_rv_n2", {30'd0, f_rv}, 32'd1);
        chk("t1_r0", f_r0, 32'd12);
        chk("t1_z0", {31'd0, f_z0}, 32'd0);
        chk("t1_p_r0", p_r0, 32'd12);
        rrdy = 2'b01;
        tick();
        rrdy = 2'b00;
        chk("t1_rv_done", {30'd0, f_rv}, 32'd0);
        chk("t1_idle", {31'd0, f_busy}, 32'd0);
        chk("t1_alu_hold", f_a, 32'd5);

        // 2/3: both requesters continuously, last winner was req 0
        valid = 2'b11; rrdy = 2'b11;
        op0 = 4'b0111; a0 = 32'd9; b0 = 32'd9;
        op1 = 4'b0100; a1 = 32'hF0; b1 = 32'h0F;
        #1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t2_f_grant%0d", i), {30'd0, f_ready}, {30'd0, fg[i]});
            chk($sformatf("t2_f_rv%0d", i), {30'd0, f_rv}, {30'd0, frv[i]});
            chk($sformatf("t3_p_grant%0d", i), {30'd0, p_ready}, {30'd0, pg[i]});
            chk($sformatf("t3_p_rv%0d", i), {30'd0, p_rv}, {30'd0, prv[i]});
            if (frv[i][0]) chk("t2_f_z0", {31'd0, f_z0}, 32'd1);
            if (frv[i][1]) chk("t2_f_r1", f_r1, 32'hFF);
            if (prv[i][0]) chk("t3_p_z0", {31'd0, p_z0}, 32'd1);
            if (prv[i][1]) chk("t3_p_r1", p_r1, 32'hFF);
            tick();
        end
        valid = 2'b00;
        tick();
        tick();
        chk("t2_f_drain", {31'd0, f_busy}, 32'd0);
        chk("t3_p_drain", {31'd0, p_busy}, 32'd0);

        // 4: requester 0 response held back for 10 cycles
        do_reset();
        valid = 2'b01; op0 = 4'b0000; a0 = 32'd3; b0 = 32'd4;
        #1;
        chk("t4_accept0", {30'd0, f_ready}, 32'd1);
        tick();
        valid = 2'b11; rrdy = 2'b10;
        op1 = 4'b0000; a1 = 32'd1; b1 = 32'd1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_f_ready%0d", i), {30'd0, f_ready},
                (i % 3 == 0) ? 32'd2 : 32'd0);
            chk($sformatf("t4_p_ready%0d", i), {30'd0, p_ready},
                (i % 3 == 0) ? 32'd2 : 32'd0);
            if (i >= 1) begin
                chk("t4_rv0", {31'd0, f_rv[0]}, 32'd1);
                chk("t4_r0", f_r0, 32'd7);
            end
            if (i % 3 == 2) chk("t4_r1", f_r1, 32'd2);
            tick();
        end
        valid = 2'b01; rrdy = 2'b11;
        #1;
        chk("t4_ready_same", {30'd0, f_ready}, 32'd0);
        tick();
        chk("t4_ready_next", {30'd0, f_ready}, 32'd1);
        valid = 2'b00;
        tick();
        tick();
        rrdy = 2'b00;
        chk("t4_drain", {31'd0, f_busy}, 32'd0);

        // 5: JAL and SLL through requester 1
        do_reset();
        valid = 2'b10; op1 = 4'b1111; a1 = '0; b1 = '0;
        c1 = 32'h0040_0010; sh1 = '0;
        #1;
        chk("t5_jal_ready", {30'd0, f_ready}, 32'd2);
        tick();
        valid = 2'b00;
        chk("t5_alu_c", f_c, 32'h0040_0010);
        chk("t5_alu_op", {28'd0, f_op}, 32'hF);
        tick();
        chk("t5_jal_rv", {30'd0, f_rv}, 32'd2);
        chk("t5_jal_r1", f_r1, 32'h0040_0014);
        rrdy = 2'b10;
        tick();
        rrdy = 2'b00;
        valid = 2'b10; op1 = 4'b0101; b1 = 32'd1; sh1 = 5'd4; c1 = '0;
        #1;
        chk("t5_sll_ready", {30'd0, f_ready}, 32'd2);
        tick();
        valid = 2'b00;
        chk("t5_alu_shamt", {27'd0, f_sh}, 32'd4);
        tick();
        chk("t5_sll_r1", f_r1, 32'h10);
        chk("t5_sll_z1", {31'd0, f_z1}, 32'd0);
        rrdy = 2'b10;
        tick();
        rrdy = 2'b00;

        // 6: reset right after an accept discards the op
        valid = 2'b01; op0 = 4'b0000; a0 = 32'd5; b0 = 32'd7;
        tick();
        valid = 2'b00;
        reset = 1'b0;
        #1;
        chk("t6_busy", {31'd0, f_busy}, 32'd0);
        chk("t6_rv", {30'd0, f_rv}, 32'd0);
        chk("t6_alu_a", f_a, 32'd0);
        tick();
        tick();
        chk("t6_rv_hold", {30'd0, f_rv}, 32'd0);
        reset = 1'b1;
        tick();
        chk("t6_rv_post", {30'd0, f_rv}, 32'd0);
        chk("t6_busy_post", {31'd0, f_busy}, 32'd0);
        valid = 2'b11;
        #1;
        chk("t6_f_first", {30'd0, f_ready}, 32'd1);
        chk("t6_p_first", {30'd0, p_ready}, 32'd1);
        valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
